// File: rtl/gpio_bank_ctrl.sv
// GPIO bank: per-pin direction/output registers, synchronised + debounced inputs,
// edge-capture interrupts aggregated onto irq, behind a strobe/ready register port.

module gpio_bank_pin #(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pin_i,
  input  logic [DEBOUNCE_BITS-1:0] thr_i,
  output logic                     stable_o,
  output logic                     rise_o,
  output logic                     fall_o
);
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     stable_q, stable_d;
  logic                     synced, upd;

  assign synced = sync_q[SYNC_STAGES-1];

  // >= rather than == so a threshold lowered mid-count still fires on the next differing cycle
  assign upd = (synced != stable_q) && (cnt_q >= thr_i);

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    stable_d = stable_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (upd) begin
      cnt_d    = '0;
      stable_d = synced;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = upd & synced;
  assign fall_o   = upd & ~synced;
endmodule

module gpio_bank_ctrl #(
  parameter int GPIO_NUMS     = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           reg_addr,
  input  logic                 reg_write_en,
  input  logic                 reg_read_en,
  input  logic [31:0]          reg_wdata,
  output logic [31:0]          reg_rdata,
  output logic                 reg_ready,
  input  logic [GPIO_NUMS-1:0] gpio_in,
  output logic [GPIO_NUMS-1:0] gpio_out,
  output logic [GPIO_NUMS-1:0] gpio_oe,
  output logic                 irq
);
  localparam logic [3:0] A_DIR  = 4'd0;
  localparam logic [3:0] A_OUT  = 4'd1;
  localparam logic [3:0] A_IN   = 4'd2;
  localparam logic [3:0] A_RISE = 4'd3;
  localparam logic [3:0] A_FALL = 4'd4;
  localparam logic [3:0] A_PEND = 4'd5;
  localparam logic [3:0] A_DEB  = 4'd6;
  localparam logic [3:0] A_SET  = 4'd7;
  localparam logic [3:0] A_CLR  = 4'd8;

  logic [GPIO_NUMS-1:0]     dir_q, dir_d, out_q, out_d;
  logic [GPIO_NUMS-1:0]     rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [GPIO_NUMS-1:0]     pend_q, pend_d, pend_clr;
  logic [DEBOUNCE_BITS-1:0] deb_q, deb_d, thr;
  logic [31:0]              rdata_q, rdata_d, rd_val;
  logic                     ready_q, ready_d;
  logic [GPIO_NUMS-1:0]     stable, rise_evt, fall_evt, wd;

  assign wd  = reg_wdata[GPIO_NUMS-1:0];
  assign thr = (deb_q == '0) ? '0 : deb_q - 1'b1;

  for (genvar g = 0; g < GPIO_NUMS; g++) begin : g_pin
    gpio_bank_pin #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_pin (
      .clk     (clk),
      .rst     (rst),
      .pin_i   (gpio_in[g]),
      .thr_i   (thr),
      .stable_o(stable[g]),
      .rise_o  (rise_evt[g]),
      .fall_o  (fall_evt[g])
    );
  end

  always_comb begin
    dir_d     = dir_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    deb_d     = deb_q;
    pend_clr  = '0;
    if (reg_write_en) begin
      case (reg_addr)
        A_DIR:   dir_d     = wd;
        A_OUT:   out_d     = wd;
        A_RISE:  rise_en_d = wd;
        A_FALL:  fall_en_d = wd;
        A_PEND:  pend_clr  = wd;
        A_DEB:   deb_d     = reg_wdata[DEBOUNCE_BITS-1:0];
        A_SET:   out_d     = out_q | wd;
        A_CLR:   out_d     = out_q & ~wd;
        default: ;
      endcase
    end
    // New edges are OR-ed in after the clear so a same-cycle edge wins
    pend_d = (pend_q & ~pend_clr) | (rise_evt & rise_en_q) | (fall_evt & fall_en_q);
  end

  always_comb begin
    rd_val = '0;
    case (reg_addr)
      A_DIR:   rd_val[GPIO_NUMS-1:0]     = dir_q;
      A_OUT:   rd_val[GPIO_NUMS-1:0]     = out_q;
      A_IN:    rd_val[GPIO_NUMS-1:0]     = stable;
      A_RISE:  rd_val[GPIO_NUMS-1:0]     = rise_en_q;
      A_FALL:  rd_val[GPIO_NUMS-1:0]     = fall_en_q;
      A_PEND:  rd_val[GPIO_NUMS-1:0]     = pend_q;
      A_DEB:   rd_val[DEBOUNCE_BITS-1:0] = deb_q;
      default: ;
    endcase
    ready_d = reg_write_en | reg_read_en;
    rdata_d = (reg_read_en && !reg_write_en) ? rd_val : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q     <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      deb_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      out_q     <= out_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      deb_q     <= deb_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign reg_ready = ready_q;
  assign gpio_oe   = dir_q;
  assign gpio_out  = out_q;
  assign irq       = |pend_q;
endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Bench for gpio_bank_ctrl: table-driven register vectors, scoreboard-checked
// read data, and hand sequences for debounce, edge/W1C collision and reset.

module tb_gpio_bank_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  reg_addr = '0;
  logic        reg_write_en = 1'b0, reg_read_en = 1'b0;
  logic [31:0] reg_wdata = '0, reg_rdata;
  logic        reg_ready, irq;
  logic [31:0] gpio_in = '0, gpio_out, gpio_oe;

  logic [3:0]  addr8 = '0;
  logic        we8 = 1'b0, re8 = 1'b0, ready8, irq8;
  logic [31:0] wd8 = '0, rdata8;
  logic [7:0]  gin8 = '0, gout8, goe8;

  always #5 clk = ~clk;

  gpio_bank_ctrl #(.GPIO_NUMS(32), .SYNC_STAGES(2), .DEBOUNCE_BITS(4)) dut (
    .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_write_en(reg_write_en),
    .reg_read_en(reg_read_en), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_ready(reg_ready), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  gpio_bank_ctrl #(.GPIO_NUMS(8), .SYNC_STAGES(2), .DEBOUNCE_BITS(4)) dut8 (
    .clk(clk), .rst(rst), .reg_addr(addr8), .reg_write_en(we8),
    .reg_read_en(re8), .reg_wdata(wd8), .reg_rdata(rdata8),
    .reg_ready(ready8), .gpio_in(gin8), .gpio_out(gout8),
    .gpio_oe(goe8), .irq(irq8)
  );

  typedef struct { logic chk; logic [31:0] rd; } exp_t;
  typedef struct {
    logic we; logic re; logic [3:0] addr; logic [31:0] wd; logic chk; logic [31:0] exp;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0, n_err = 0;
  vec_t vt[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; drives one strobe cycle and returns at the next negedge
  task automatic issue(input logic we, input logic re, input logic [3:0] a,
                       input logic [31:0] wd, input logic chk, input logic [31:0] ex);
    exp_t e;
    reg_write_en = we; reg_read_en = re; reg_addr = a; reg_wdata = wd;
    e.chk = chk; e.rd = ex;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] wd);
    issue(1'b1, 1'b0, a, wd, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] ex);
    issue(1'b0, 1'b1, a, 32'h0, 1'b1, ex);
  endtask

  task automatic idle();
    reg_write_en = 1'b0; reg_read_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sbq.size() > 0; i++) @(negedge clk);
    check("ready_missing", sbq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reg_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL spurious_ready: got ready=1 expected no access pending");
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.chk) check("rdata", reg_rdata, mon_e.rd);
      end
    end else begin
      check("rdata_idle", reg_rdata, 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{1'b0, 1'b1, 4'd2,  32'h0,        1'b1, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 4'd0,  32'h0000FFFF, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 4'd1,  32'h000000A5, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 4'd7,  32'h00000100, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 1'b0, 4'd8,  32'h00000001, 1'b0, 32'h0};
    vt[5]  = '{1'b0, 1'b1, 4'd1,  32'h0,        1'b1, 32'h000001A4};
    vt[6]  = '{1'b0, 1'b1, 4'd0,  32'h0,        1'b1, 32'h0000FFFF};
    vt[7]  = '{1'b0, 1'b1, 4'd7,  32'h0,        1'b1, 32'h0};
    vt[8]  = '{1'b0, 1'b1, 4'd8,  32'h0,        1'b1, 32'h0};
    vt[9]  = '{1'b1, 1'b0, 4'd12, 32'hFFFFFFFF, 1'b0, 32'h0};
    vt[10] = '{1'b0, 1'b1, 4'd12, 32'h0,        1'b1, 32'h0};
    vt[11] = '{1'b1, 1'b0, 4'd6,  32'hFFFFFFF5, 1'b0, 32'h0};
    vt[12] = '{1'b0, 1'b1, 4'd6,  32'h0,        1'b1, 32'h00000005};
    vt[13] = '{1'b0, 1'b1, 4'd5,  32'h0,        1'b1, 32'h0};
    vt[14] = '{1'b0, 1'b1, 4'd3,  32'h0,        1'b1, 32'h0};
    vt[15] = '{1'b0, 1'b1, 4'd1,  32'h0,        1'b1, 32'h000001A4};

    repeat (2) @(negedge clk);
    check("rst_oe", gpio_oe, 32'h0);
    check("rst_out", gpio_out, 32'h0);
    check("rst_ready", {31'h0, reg_ready}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back register vectors
    for (int i = 0; i < 16; i++)
      issue(vt[i].we, vt[i].re, vt[i].addr, vt[i].wd, vt[i].chk, vt[i].exp);
    idle();
    drain();
    check("oe_after_dir", gpio_oe, 32'h0000FFFF);
    check("out_after_setclr", gpio_out, 32'h000001A4);

    // Simultaneous read+write: write lands, one ready, rdata 0
    issue(1'b1, 1'b1, 4'd1, 32'h00000055, 1'b1, 32'h0);
    idle();
    drain();
    check("out_rw", gpio_out, 32'h00000055);
    rd(4'd1, 32'h00000055);
    idle();
    drain();

    // Asynchronous reset mid-access: immediate clear, no ready for the aborted write
    reg_write_en = 1'b1; reg_addr = 4'd1; reg_wdata = 32'h000000FF;
    #2 rst = 1'b1;
    #1;
    check("async_oe", gpio_oe, 32'h0);
    check("async_out", gpio_out, 32'h0);
    check("async_ready", {31'h0, reg_ready}, 32'h0);
    @(negedge clk);
    reg_write_en = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("aborted_write", gpio_out, 32'h0);

    // Debounce T=4: 3-cycle glitch on pin 3 is filtered
    wr(4'd6, 32'h4);
    wr(4'd3, 32'h8);
    idle();
    gpio_in[3] = 1'b1;
    repeat (3) @(negedge clk);
    gpio_in[3] = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_irq", {31'h0, irq}, 32'h0);
    rd(4'd2, 32'h0);
    rd(4'd5, 32'h0);
    idle();
    drain();

    // Held level reaches IN/PEND at edge 2+4
    gpio_in[3] = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("irq_edge5", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 check("irq_edge6", {31'h0, irq}, 32'h1);
    @(negedge clk);
    rd(4'd2, 32'h8);
    rd(4'd5, 32'h8);
    wr(4'd5, 32'h8);
    idle();
    drain();
    check("irq_cleared", {31'h0, irq}, 32'h0);

    // Falling edge on pin 5 collides with its W1C: set wins
    wr(4'd4, 32'h20);
    idle();
    gpio_in[5] = 1'b1;
    repeat (10) @(negedge clk);
    rd(4'd5, 32'h0);
    idle();
    drain();
    gpio_in[5] = 1'b0;
    repeat (5) @(negedge clk);
    wr(4'd5, 32'h20);
    idle();
    rd(4'd5, 32'h20);
    idle();
    drain();
    check("collision_irq", {31'h0, irq}, 32'h1);
    wr(4'd5, 32'h20);
    idle();
    drain();
    check("w1c_irq", {31'h0, irq}, 32'h0);
    rd(4'd5, 32'h0);
    idle();
    drain();

    // T=0: single-cycle pulse on pin 0 passes, IN updates at edge 3
    wr(4'd6, 32'h0);
    wr(4'd3, 32'h1);
    idle();
    drain();
    gpio_in[0] = 1'b1;
    @(negedge clk);
    gpio_in[0] = 1'b0;
    @(posedge clk);
    #1 check("t0_irq_edge2", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 check("t0_irq_edge3", {31'h0, irq}, 32'h1);
    @(negedge clk);
    rd(4'd2, 32'h9);
    rd(4'd2, 32'h8);
    rd(4'd5, 32'h1);
    idle();
    drain();

    // 8-pin build: upper write bits ignored
    we8 = 1'b1; addr8 = 4'd0; wd8 = 32'hFFFFFFFF;
    @(posedge clk);
    #1 check("n8_wr_ready", {31'h0, ready8}, 32'h1);
    @(negedge clk);
    we8 = 1'b0; re8 = 1'b1;
    @(posedge clk);
    #1 check("n8_rd_ready", {31'h0, ready8}, 32'h1);
    check("n8_dir", rdata8, 32'h000000FF);
    @(negedge clk);
    re8 = 1'b0;
    @(posedge clk);
    #1 check("n8_ready_drop", {31'h0, ready8}, 32'h0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
